// File: rtl/updown_ctrl.sv
// Direction controller for updown_counter: debounced button toggle plus
// optional automatic reversal at the count limits.
module updown_ctrl #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn,
    input  logic             auto_rev,
    input  logic [WIDTH-1:0] count,
    output logic             updown,
    output logic             dir_change,
    output logic             btn_level
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DB_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] CNT_TOP = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] CNT_BOT = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } db_state_t;

    typedef enum logic {
        DOWN,
        UP
    } dir_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    db_state_t              db_state;
    logic [CW-1:0]          db_cnt;
    logic                   level_q;
    logic                   press;
    logic                   auto_req;
    dir_t                   dir;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_state  <= IDLE_LO;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            unique case (db_state)
                IDLE_LO: begin
                    if (btn_s) begin
                        db_state <= CHK_HI;
                        db_cnt   <= DB_ONE;
                    end
                end
                CHK_HI: begin
                    if (!btn_s) begin
                        db_state <= IDLE_LO;
                        db_cnt   <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        db_state  <= IDLE_HI;
                        db_cnt    <= '0;
                        btn_level <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!btn_s) begin
                        db_state <= CHK_LO;
                        db_cnt   <= DB_ONE;
                    end
                end
                CHK_LO: begin
                    if (btn_s) begin
                        db_state <= IDLE_HI;
                        db_cnt   <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        db_state  <= IDLE_LO;
                        db_cnt    <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                default: begin
                    db_state <= IDLE_LO;
                    db_cnt   <= '0;
                end
            endcase
        end
    end

    assign press = btn_level & ~level_q;

    // Fire one count early: the counter samples updown on the edge it moves.
    assign auto_req = auto_rev &
                      (((dir == UP) && (count == CNT_TOP)) ||
                       ((dir == DOWN) && (count == CNT_BOT)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q    <= 1'b0;
            dir        <= DOWN;
            dir_change <= 1'b0;
        end else begin
            level_q <= btn_level;
            if (press || auto_req) begin
                dir        <= (dir == UP) ? DOWN : UP;
                dir_change <= 1'b1;
            end else begin
                dir_change <= 1'b0;
            end
        end
    end

    assign updown = (dir == UP);

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed bench for updown_ctrl: vector table plus hand-written
// sequences for simultaneous events and reset during debounce.
module tb_updown_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn;
    logic       auto_rev;
    logic [3:0] count;
    logic       updown;
    logic       dir_change;
    logic       btn_level;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       btn;
        logic       ar;
        logic [3:0] cnt;
        logic       ud;
        logic       dc;
        logic       bl;
    } vec_t;

    vec_t tbl[$];

    updown_ctrl #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DB_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn(btn),
        .auto_rev(auto_rev),
        .count(count),
        .updown(updown),
        .dir_change(dir_change),
        .btn_level(btn_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ud, input logic dc,
                             input logic bl);
        check({tag, " updown"}, updown, ud);
        check({tag, " dir_change"}, dir_change, dc);
        check({tag, " btn_level"}, btn_level, bl);
    endtask

    task automatic add(input logic b, input logic ar, input logic [3:0] c,
                       input logic ud, input logic dc, input logic bl);
        vec_t v;
        v.btn = b; v.ar = ar; v.cnt = c;
        v.ud = ud; v.dc = dc; v.bl = bl;
        tbl.push_back(v);
    endtask

    // Drive inputs at the falling edge, then check after the next rise.
    task automatic cyc(input logic b, input logic ar, input logic [3:0] c);
        btn = b; auto_rev = ar; count = c;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // clean press: btn_level rises on the 6th edge counting the sampling edge
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 1);
        for (int i = 8; i <= 12; i++) add(1, 0, 0, 1, 0, 1);
        // release: level falls, no toggle
        for (int i = 1; i <= 5; i++) add(0, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 1, 0, 0);
        // bounce rejection
        add(1, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) add(0, 0, 0, 1, 0, 0);
        // auto reverse at top and bottom
        add(0, 1, 13, 1, 0, 0);
        add(0, 1, 14, 0, 1, 0);
        add(0, 1, 15, 0, 0, 0);
        add(0, 1, 14, 0, 0, 0);
        add(0, 1, 2, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        // auto_rev disabled
        add(0, 0, 13, 1, 0, 0);
        add(0, 0, 14, 1, 0, 0);
        add(0, 0, 15, 1, 0, 0);
        add(0, 0, 14, 1, 0, 0);
        add(0, 0, 2, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        // back-to-back reversals
        add(0, 1, 14, 0, 1, 0);
        add(0, 1, 1, 1, 1, 0);
        add(0, 1, 5, 1, 0, 0);
        add(0, 1, 14, 0, 1, 0);
        add(0, 1, 5, 0, 0, 0);

        // reset with btn high and trigger count present
        btn = 1; auto_rev = 1; count = 14;
        reset = 1'b0;
        #1;
        check_all("reset_async", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_all($sformatf("reset_cyc%0d", i), 0, 0, 0);
        end
        btn = 0; auto_rev = 0; count = 0;
        reset = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_all("post_reset", 0, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].btn, tbl[i].ar, tbl[i].cnt);
            check_all($sformatf("vec%0d", i), tbl[i].ud, tbl[i].dc, tbl[i].bl);
        end

        // simultaneous press and auto reversal while down
        for (int i = 1; i <= 5; i++) cyc(1, 1, 5);
        check_all("sim_pre", 0, 0, 0);
        cyc(1, 1, 5);
        check_all("sim_level", 0, 0, 1);
        cyc(1, 1, 1);
        check_all("sim_toggle", 1, 1, 1);
        cyc(1, 1, 5);
        check_all("sim_after", 1, 0, 1);

        // release, then reset while in CHK_HI
        for (int i = 0; i < 8; i++) cyc(0, 0, 5);
        check_all("rel_done", 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 5);
        check_all("chk_hi", 1, 0, 0);
        reset = 1'b0;
        #1;
        check_all("mid_db_reset", 0, 0, 0);
        @(posedge clock);
        @(negedge clock);
        check_all("mid_db_hold", 0, 0, 0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 5);
            check_all($sformatf("rearm%0d", i), 0, 0, 0);
        end
        cyc(1, 0, 5);
        check_all("rearm_level", 0, 0, 1);
        cyc(1, 0, 5);
        check_all("rearm_toggle", 1, 1, 1);
        cyc(1, 0, 5);
        check_all("rearm_after", 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
